// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
package ifetch_pkg;

   localparam int HW_BITS    = 16;
   localparam int ILEN_BYTES = 2;
   localparam int WORD_BYTES = 4;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic {
      ST_IDLE,
      ST_REQ
   } fetch_state_t;

   // Halfwords taken from one fetched word: the low half is skipped when
   // the fetch target sits in the upper half of the word.
   function automatic logic [1:0] halves_from_word(input logic skip_lo);
      return skip_lo ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/ifetch_if.sv
// Memory read port and decode-side instruction stream of the fetch unit.
interface ifetch_if
   import ifetch_pkg::*;
#(
   parameter int RV = 32
);

   logic                mem_req;
   logic [RV-1:0]       mem_addr;
   logic                mem_ack;
   logic [31:0]         mem_rdata;

   logic [HW_BITS-1:0]  ins;
   logic                idone;
   logic [RV-1:0]       ins_pc;
   logic                take;
   logic                redirect;
   logic [RV-1:0]       redirect_pc;

   // The fetch unit side.
   modport master (
      output mem_req, mem_addr, ins, idone, ins_pc,
      input  mem_ack, mem_rdata, take, redirect, redirect_pc
   );

   // Memory plus core side.
   modport slave (
      input  mem_req, mem_addr, ins, idone, ins_pc,
      output mem_ack, mem_rdata, take, redirect, redirect_pc
   );

endinterface

// File: rtl/ifetch_queue.sv
// Circular halfword FIFO: up to two pushes and one pop per cycle, flushable.
// The caller guarantees that pushes never exceed the free space.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter  int QDEPTH = 4,
   localparam int AW     = $clog2(QDEPTH),
   localparam int CW     = AW + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic [1:0]         push_cnt,
   input  logic [HW_BITS-1:0] push_a,
   input  logic [HW_BITS-1:0] push_b,
   input  logic               pop,
   output logic [HW_BITS-1:0] head,
   output logic [CW-1:0]      count
);

   logic [HW_BITS-1:0] mem [QDEPTH];
   logic [AW-1:0]      rd_ptr;
   logic [AW-1:0]      wr_ptr;

   // Storage writes; push_a lands first, push_b at the following slot.
   always_ff @(posedge clk) begin
      if (!reset && !flush) begin
         if (push_cnt != 2'd0) mem[wr_ptr] <= push_a;
         if (push_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= push_b;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the queue.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_cnt);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count  <= count + CW'(push_cnt) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: word reads from memory, split into halfword
// instructions, queued and presented one per cycle to decode.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | no read outstanding; issue one when room for a full word
//  ST_REQ  | read outstanding, mem_req/mem_addr held until mem_ack;
//          | drop marks the response as stale (redirect happened)
module ifetch
   import ifetch_pkg::*;
#(
   parameter int            RV       = 32,
   parameter int            QDEPTH   = 4,
   parameter logic [RV-1:0] RESET_PC = RV'(DEFAULT_RESET_PC)
) (
   input  logic     clk,
   input  logic     reset,
   ifetch_if.master bus
);

   localparam int            CW        = $clog2(QDEPTH) + 1;
   localparam logic [RV-1:0] WORD_MASK = ~RV'(WORD_BYTES - 1);
   localparam logic [RV-1:0] HW_MASK   = ~RV'(ILEN_BYTES - 1);

   fetch_state_t       state;
   logic               req;
   logic [RV-1:0]      req_addr;
   logic               drop;
   logic               skip_lo;
   logic [RV-1:0]      pc;
   logic [RV-1:0]      faddr;

   logic [CW-1:0]      q_count;
   logic [HW_BITS-1:0] q_head;
   logic [1:0]         push_cnt;
   logic [HW_BITS-1:0] push_a;
   logic [HW_BITS-1:0] push_b;
   logic               pop;
   logic               idone;
   logic               room;

   assign idone = (q_count != '0);
   assign room  = (q_count <= CW'(QDEPTH - 2));

   // Queue push/pop decisions; a redirect suppresses both.
   always_comb begin
      push_cnt = 2'd0;
      push_a   = skip_lo ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      push_b   = bus.mem_rdata[31:16];
      pop      = idone && bus.take && !bus.redirect;
      if (state == ST_REQ && bus.mem_ack && !drop && !bus.redirect)
         push_cnt = halves_from_word(skip_lo);
   end

   // Request FSM with drop/skip_lo flags and the pc/faddr counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         req      <= 1'b0;
         req_addr <= RESET_PC & WORD_MASK;
         drop     <= 1'b0;
         pc       <= RESET_PC;
         faddr    <= RESET_PC & WORD_MASK;
         skip_lo  <= RESET_PC[1];
      end else begin
         if (pop) pc <= pc + RV'(ILEN_BYTES);

         case (state)
            ST_IDLE: begin
               if (!bus.redirect && room) begin
                  state    <= ST_REQ;
                  req      <= 1'b1;
                  req_addr <= faddr;
               end
            end
            ST_REQ: begin
               if (bus.mem_ack) begin
                  state <= ST_IDLE;
                  req   <= 1'b0;
                  drop  <= 1'b0;
                  if (push_cnt != 2'd0) begin
                     faddr   <= faddr + RV'(WORD_BYTES);
                     skip_lo <= 1'b0;
                  end
               end else if (bus.redirect) begin
                  drop <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               req   <= 1'b0;
            end
         endcase

         // Redirect wins over the pc/faddr updates above.
         if (bus.redirect) begin
            pc      <= bus.redirect_pc & HW_MASK;
            faddr   <= bus.redirect_pc & WORD_MASK;
            skip_lo <= bus.redirect_pc[1];
         end
      end
   end

   ifetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .flush    (bus.redirect),
      .push_cnt (push_cnt),
      .push_a   (push_a),
      .push_b   (push_b),
      .pop      (pop),
      .head     (q_head),
      .count    (q_count)
   );

   assign bus.mem_req  = req;
   assign bus.mem_addr = req_addr;
   assign bus.ins      = q_head;
   assign bus.idone    = idone;
   assign bus.ins_pc   = pc;

endmodule
